// File: rtl/x1_bus_pkg.sv
// ---------------------------------------------------------------------------
// x1_bus_pkg
// Shared definitions for the X1 system bus initiator:
//   bus_state_t    : bus-cycle state encoding (IDLE, T1, T2, TW, T3)
//   cycle_type_t   : cycle kind (MEM_RD, MEM_WR, IO_RD, IO_WR)
//   TIMEOUT_CYCLES : consecutive WAIT_n-low TW cycles before a forced end
//                    (only meaningful when X1_BUSINIT_TIMEOUT_EN is defined)
//   TW_W           : width of the fixed wait-state count (0..7)
// ---------------------------------------------------------------------------
package x1_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4
  } bus_state_t;

  // Encoded as {io, we}.
  typedef enum logic [1:0] {
    MEM_RD = 2'b00,
    MEM_WR = 2'b01,
    IO_RD  = 2'b10,
    IO_WR  = 2'b11
  } cycle_type_t;

  localparam int TIMEOUT_CYCLES = 256;
  localparam int TW_W           = 3;

  function automatic cycle_type_t make_cycle(input logic io, input logic we);
    return cycle_type_t'({io, we});
  endfunction

  function automatic logic cycle_is_io(input cycle_type_t t);
    return (t == IO_RD) || (t == IO_WR);
  endfunction

  function automatic logic cycle_is_wr(input cycle_type_t t);
    return (t == MEM_WR) || (t == IO_WR);
  endfunction

endpackage

// File: rtl/x1_bus_waitgen.sv
// ---------------------------------------------------------------------------
// x1_bus_waitgen
// Wait-state generator for the X1 bus initiator. Holds the fixed-wait
// down-counter, samples WAIT_n and (optionally) runs the stuck-WAIT timeout.
// Produces a single "advance to T3" decision for the FSM in T2/TW.
//
// Optional feature macro: X1_BUSINIT_TIMEOUT_EN (adds the timeout output).
//
// Ports:
//   I_CLK      in  T-state clock
//   I_RESET_n  in  asynchronous active-low reset
//   state      in  current bus-cycle state of the initiator
//   fixed_tw   in  fixed wait count for the cycle in flight, loaded in T1
//   wait_n     in  bus WAIT_n, active-low
//   adv_t3     out leave T2/TW for T3 at the next edge
//   timeout    out (macro only) TW forced to end by the stuck-WAIT timer
// ---------------------------------------------------------------------------
module x1_bus_waitgen
  import x1_bus_pkg::*;
(
  input  logic            I_CLK,
  input  logic            I_RESET_n,
  input  bus_state_t      state,
  input  logic [TW_W-1:0] fixed_tw,
  input  logic            wait_n,
  output logic            adv_t3
`ifdef X1_BUSINIT_TIMEOUT_EN
  ,
  output logic            timeout
`endif
);

  logic [TW_W-1:0] tw_cnt;

  // The count is loaded during T1 so it is ready when T2 decides; each TW
  // clock consumes one count. WAIT_n is only honoured once the fixed waits
  // are exhausted (count 0 in T2, or the last counted TW onwards).
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      tw_cnt <= '0;
    end else begin
      case (state)
        ST_T1: tw_cnt <= fixed_tw;
        ST_TW: if (tw_cnt != '0) tw_cnt <= tw_cnt - TW_W'(1);
        default: ;
      endcase
    end
  end

`ifdef X1_BUSINIT_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Counts consecutive TW clocks with WAIT_n low; the 256th such clock ends
  // the cycle.
  assign timeout = (state == ST_TW) && !wait_n &&
                   (to_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      to_cnt <= '0;
    end else if ((state == ST_TW) && !wait_n) begin
      to_cnt <= to_cnt + 8'd1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  logic timeout;
  assign timeout = 1'b0;
`endif

  always_comb begin
    adv_t3 = 1'b0;
    case (state)
      ST_T2:   adv_t3 = (tw_cnt == '0) && wait_n;
      ST_TW:   adv_t3 = timeout || ((tw_cnt <= TW_W'(1)) && wait_n);
      default: adv_t3 = 1'b0;
    endcase
  end

endmodule

// File: rtl/x1_bus_initiator.sv
// ---------------------------------------------------------------------------
// x1_bus_initiator
// Z80-style bus-cycle initiator for the X1 system bus. Converts a simple
// request/acknowledge interface into memory or I/O read/write cycles with
// MREQ_n/IORQ_n/RD_n/WR_n strobes, fixed wait states and WAIT_n extension.
//
// Optional feature macro: X1_BUSINIT_TIMEOUT_EN
//   defined   : stuck WAIT_n ends the cycle after 256 TW clocks, reads
//               return 8'hFF, O_TIMEOUT pulses with O_ACK.
//   undefined : TW may last indefinitely, no O_TIMEOUT port.
//
// Parameters:
//   MEM_TW  fixed wait states for memory cycles (0..7)
//   IO_TW   fixed wait states for I/O cycles (0..7)
//
// Ports:
//   I_CLK      in   T-state clock, rising edge
//   I_RESET_n  in   asynchronous active-low reset
//   I_REQ      in   request, accepted only in IDLE
//   I_IO       in   1 = I/O cycle, 0 = memory cycle
//   I_WE       in   1 = write, 0 = read
//   I_ADDR     in   cycle address
//   I_WDATA    in   write data
//   O_BUSY     out  high T1..T3
//   O_ACK      out  one-clock completion pulse (the IDLE clock after T3)
//   O_RDATA    out  read data, held until the next read completes
//   O_A        out  bus address, held in IDLE
//   O_DO       out  bus write data, held in IDLE
//   O_DOE      out  bus data-out enable (writes, T1..T3)
//   I_DI       in   bus read data, captured on T3 -> IDLE
//   O_MREQ_n, O_IORQ_n, O_RD_n, O_WR_n  out  bus strobes, active-low
//   I_WAIT_n   in   bus wait request, active-low
//   O_TIMEOUT  out  (macro only) cycle was ended by the WAIT_n timeout
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no cycle; ACK clock after a cycle; I_REQ sampled here
// T1    | address (and write data) on the bus, no strobes
// T2    | strobes active; ends in TW if waits pending or WAIT_n low
// TW    | wait state, repeats for fixed waits and WAIT_n low samples
// T3    | last strobe clock; read data captured on the exit edge
// ---------------------------------------------------------------------------
module x1_bus_initiator
  import x1_bus_pkg::*;
#(
  parameter int unsigned MEM_TW = 0,
  parameter int unsigned IO_TW  = 1
) (
  input  logic        I_CLK,
  input  logic        I_RESET_n,
  input  logic        I_REQ,
  input  logic        I_IO,
  input  logic        I_WE,
  input  logic [15:0] I_ADDR,
  input  logic [7:0]  I_WDATA,
  output logic        O_BUSY,
  output logic        O_ACK,
  output logic [7:0]  O_RDATA,
  output logic [15:0] O_A,
  output logic [7:0]  O_DO,
  output logic        O_DOE,
  input  logic [7:0]  I_DI,
  output logic        O_MREQ_n,
  output logic        O_IORQ_n,
  output logic        O_RD_n,
  output logic        O_WR_n,
  input  logic        I_WAIT_n
`ifdef X1_BUSINIT_TIMEOUT_EN
  ,
  output logic        O_TIMEOUT
`endif
);

  localparam logic [TW_W-1:0] MEM_TW_V = TW_W'(MEM_TW);
  localparam logic [TW_W-1:0] IO_TW_V  = TW_W'(IO_TW);

  bus_state_t      state;
  cycle_type_t     cyc_type;
  logic [TW_W-1:0] fixed_tw;
  logic            adv_t3;
  logic            timeout;
  logic            timed_out;

  assign fixed_tw = cycle_is_io(cyc_type) ? IO_TW_V : MEM_TW_V;

  x1_bus_waitgen u_waitgen (
    .I_CLK     (I_CLK),
    .I_RESET_n (I_RESET_n),
    .state     (state),
    .fixed_tw  (fixed_tw),
    .wait_n    (I_WAIT_n),
    .adv_t3    (adv_t3)
`ifdef X1_BUSINIT_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

`ifndef X1_BUSINIT_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  // All bus outputs are set on the edge that enters the state they belong
  // to, so they are flop outputs and only move on I_CLK (or reset).
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state     <= ST_IDLE;
      cyc_type  <= MEM_RD;
      timed_out <= 1'b0;
      O_BUSY    <= 1'b0;
      O_ACK     <= 1'b0;
      O_RDATA   <= 8'h00;
      O_A       <= 16'h0000;
      O_DO      <= 8'h00;
      O_DOE     <= 1'b0;
      O_MREQ_n  <= 1'b1;
      O_IORQ_n  <= 1'b1;
      O_RD_n    <= 1'b1;
      O_WR_n    <= 1'b1;
    end else begin
      O_ACK <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (I_REQ) begin
            state     <= ST_T1;
            cyc_type  <= make_cycle(I_IO, I_WE);
            timed_out <= 1'b0;
            O_A       <= I_ADDR;
            if (I_WE) O_DO <= I_WDATA;
            O_DOE     <= I_WE;
            O_BUSY    <= 1'b1;
          end
        end
        ST_T1: begin
          state    <= ST_T2;
          O_MREQ_n <= cycle_is_io(cyc_type);
          O_IORQ_n <= !cycle_is_io(cyc_type);
          O_RD_n   <= cycle_is_wr(cyc_type);
          O_WR_n   <= !cycle_is_wr(cyc_type);
        end
        ST_T2, ST_TW: begin
          if (adv_t3) begin
            state     <= ST_T3;
            timed_out <= timeout;
          end else begin
            state <= ST_TW;
          end
        end
        ST_T3: begin
          state    <= ST_IDLE;
          O_MREQ_n <= 1'b1;
          O_IORQ_n <= 1'b1;
          O_RD_n   <= 1'b1;
          O_WR_n   <= 1'b1;
          O_DOE    <= 1'b0;
          O_BUSY   <= 1'b0;
          O_ACK    <= 1'b1;
          if (!cycle_is_wr(cyc_type)) O_RDATA <= timed_out ? 8'hFF : I_DI;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef X1_BUSINIT_TIMEOUT_EN
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      O_TIMEOUT <= 1'b0;
    end else begin
      O_TIMEOUT <= (state == ST_T3) && timed_out;
    end
  end
`endif

endmodule

// File: tb/tb_x1_bus_initiator.sv
`timescale 1ns/1ps
module tb_x1_bus_initiator;

  localparam int N_MEM = 0;
  localparam int N_IO  = 1;

  logic        I_CLK = 1'b0;
  logic        I_RESET_n = 1'b0;
  logic        I_REQ = 1'b0;
  logic        I_IO = 1'b0;
  logic        I_WE = 1'b0;
  logic [15:0] I_ADDR = 16'h0000;
  logic [7:0]  I_WDATA = 8'h00;
  logic [7:0]  I_DI = 8'h00;
  logic        I_WAIT_n = 1'b1;
  logic        O_BUSY, O_ACK, O_DOE;
  logic [7:0]  O_RDATA, O_DO;
  logic [15:0] O_A;
  logic        O_MREQ_n, O_IORQ_n, O_RD_n, O_WR_n;
`ifdef X1_BUSINIT_TIMEOUT_EN
  logic        O_TIMEOUT;
`endif

  x1_bus_initiator #(.MEM_TW(N_MEM), .IO_TW(N_IO)) dut (
    .I_CLK     (I_CLK),
    .I_RESET_n (I_RESET_n),
    .I_REQ     (I_REQ),
    .I_IO      (I_IO),
    .I_WE      (I_WE),
    .I_ADDR    (I_ADDR),
    .I_WDATA   (I_WDATA),
    .O_BUSY    (O_BUSY),
    .O_ACK     (O_ACK),
    .O_RDATA   (O_RDATA),
    .O_A       (O_A),
    .O_DO      (O_DO),
    .O_DOE     (O_DOE),
    .I_DI      (I_DI),
    .O_MREQ_n  (O_MREQ_n),
    .O_IORQ_n  (O_IORQ_n),
    .O_RD_n    (O_RD_n),
    .O_WR_n    (O_WR_n),
    .I_WAIT_n  (I_WAIT_n)
`ifdef X1_BUSINIT_TIMEOUT_EN
    ,
    .O_TIMEOUT (O_TIMEOUT)
`endif
  );

  always #5 I_CLK = ~I_CLK;

  int cyc = 0;
  always @(posedge I_CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          ack_cyc;
    bit          io;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          strobe_n;
    bit          tmo;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  last_rdata = 8'h00;

  // Reference timing: clocks are numbered from the acceptance edge
  // (edge 1 ends T1, edge 2 ends T2). The cycle leaves its wait phase at the
  // first edge that is both past the fixed waits (edge n+2) and sees WAIT_n
  // high (WAIT_n is held low for edges 1..k). T3 follows, then the ACK clock.
  function automatic int exit_edge(input int n, input int k);
    int d0;
    d0 = n + 2;
    return (k + 1 > d0) ? k + 1 : d0;
  endfunction

  task automatic run_txn(input bit io, input bit we, input logic [15:0] a,
                         input logic [7:0] wd, input logic [7:0] di,
                         input int k, input bit hold);
    exp_t e;
    int   n;
    int   ex;
    bit   got;
    n = io ? N_IO : N_MEM;
    I_REQ = 1'b1; I_IO = io; I_WE = we; I_ADDR = a; I_WDATA = wd; I_DI = di;
    I_WAIT_n = (k == 0);
    @(posedge I_CLK); #1;
    ex = exit_edge(n, k);
    e.tmo = 1'b0;
`ifdef X1_BUSINIT_TIMEOUT_EN
    if (ex > 258) begin
      ex = 258;
      e.tmo = 1'b1;
    end
`endif
    e.ack_cyc  = cyc + ex + 1;
    e.io       = io;
    e.we       = we;
    e.addr     = a;
    e.wdata    = wd;
    e.strobe_n = ex;
    if (!we) last_rdata = e.tmo ? 8'hFF : di;
    e.rdata    = last_rdata;
    sb.push_back(e);
    I_REQ = hold; I_IO = 1'($urandom); I_WE = 1'($urandom);
    I_ADDR = 16'($urandom); I_WDATA = 8'($urandom);
    got = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge I_CLK); #1;
      if (i == k) I_WAIT_n = 1'b1;
      if (O_ACK) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ack_wait_expired", 32'(got), 32'd1);
    I_WAIT_n = 1'b1;
    I_DI = 8'($urandom);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  exp_t me;
  int   busy_n = 0, mreq_n = 0, iorq_n = 0, rd_n = 0, wr_n = 0, doe_n = 0;
  int   a_bad = 0, do_bad = 0, excl_bad = 0;

  always @(negedge I_CLK) begin
    if (!I_RESET_n) begin
      busy_n = 0; mreq_n = 0; iorq_n = 0; rd_n = 0; wr_n = 0; doe_n = 0;
      a_bad = 0; do_bad = 0; excl_bad = 0;
    end else begin
      if (!O_MREQ_n && !O_IORQ_n) excl_bad++;
      if (!O_RD_n && !O_WR_n) excl_bad++;
      if (sb.size() > 0) begin
        me = sb[0];
        if (O_BUSY) begin
          busy_n++;
          if (O_A !== me.addr) a_bad++;
        end
        if (!O_MREQ_n) mreq_n++;
        if (!O_IORQ_n) iorq_n++;
        if (!O_RD_n) rd_n++;
        if (!O_WR_n) wr_n++;
        if (O_DOE) begin
          doe_n++;
          if (O_DO !== me.wdata) do_bad++;
        end
      end
      if (O_ACK) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(O_ACK), 32'd0);
        end else begin
          me = sb.pop_front();
          chk("ack_latency", 32'(cyc), 32'(me.ack_cyc));
          chk("rdata", 32'(O_RDATA), 32'(me.rdata));
          chk("addr_hold", 32'(O_A), 32'(me.addr));
          chk("addr_stable", 32'(a_bad), 32'd0);
          chk("busy_len", 32'(busy_n), 32'(me.strobe_n + 1));
          chk("mreq_len", 32'(mreq_n), me.io ? 32'd0 : 32'(me.strobe_n));
          chk("iorq_len", 32'(iorq_n), me.io ? 32'(me.strobe_n) : 32'd0);
          chk("rd_len", 32'(rd_n), me.we ? 32'd0 : 32'(me.strobe_n));
          chk("wr_len", 32'(wr_n), me.we ? 32'(me.strobe_n) : 32'd0);
          chk("doe_len", 32'(doe_n), me.we ? 32'(me.strobe_n + 1) : 32'd0);
          chk("do_value", 32'(do_bad), 32'd0);
          chk("strobe_exclusive", 32'(excl_bad), 32'd0);
          chk("idle_strobes", 32'({O_MREQ_n, O_IORQ_n, O_RD_n, O_WR_n, O_DOE, O_BUSY}), 32'h3C);
`ifdef X1_BUSINIT_TIMEOUT_EN
          chk("timeout_flag", 32'(O_TIMEOUT), 32'(me.tmo));
`endif
        end
        busy_n = 0; mreq_n = 0; iorq_n = 0; rd_n = 0; wr_n = 0; doe_n = 0;
        a_bad = 0; do_bad = 0; excl_bad = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int gap;

    I_RESET_n = 1'b0;
    repeat (3) @(posedge I_CLK);
    #1;
    chk("rst_strobes", 32'({O_MREQ_n, O_IORQ_n, O_RD_n, O_WR_n}), 32'hF);
    chk("rst_a", 32'(O_A), 32'd0);
    chk("rst_do", 32'(O_DO), 32'd0);
    chk("rst_ctrl", 32'({O_DOE, O_ACK, O_BUSY}), 32'd0);
    chk("rst_rdata", 32'(O_RDATA), 32'd0);
    I_RESET_n = 1'b1;
    @(posedge I_CLK); #1;

    // Directed cases
    run_txn(1'b0, 1'b0, 16'h8000, 8'h00, 8'h5A, 0, 1'b0);
    run_txn(1'b1, 1'b1, 16'h1B00, 8'h3C, 8'h00, 0, 1'b0);
    run_txn(1'b1, 1'b0, 16'h00F3, 8'h00, 8'hC7, 5, 1'b0);
    run_txn(1'b0, 1'b1, 16'h2222, 8'h81, 8'h00, 0, 1'b0);
    run_txn(1'b0, 1'b0, 16'h7FFF, 8'h00, 8'h19, 4, 1'b0);

    // Reset during T2 of a write
    I_REQ = 1'b1; I_IO = 1'b0; I_WE = 1'b1; I_ADDR = 16'h4321; I_WDATA = 8'hA5;
    I_WAIT_n = 1'b1;
    @(posedge I_CLK); #1;
    I_REQ = 1'b0;
    @(posedge I_CLK); #1;
    chk("rst_pre_wr_low", 32'(O_WR_n), 32'd0);
    #2 I_RESET_n = 1'b0;
    #1;
    chk("rst_async_strobes", 32'({O_MREQ_n, O_IORQ_n, O_RD_n, O_WR_n}), 32'hF);
    chk("rst_async_ctrl", 32'({O_DOE, O_BUSY, O_ACK}), 32'd0);
    @(posedge I_CLK); #1;
    I_RESET_n = 1'b1;
    last_rdata = 8'h00;
    seen = 1'b0;
    repeat (6) begin
      @(posedge I_CLK); #1;
      if (O_ACK) seen = 1'b1;
    end
    chk("rst_no_ack", 32'(seen), 32'd0);
    run_txn(1'b0, 1'b1, 16'h0101, 8'h66, 8'h00, 0, 1'b0);
    run_txn(1'b1, 1'b0, 16'h0202, 8'h00, 8'h99, 2, 1'b0);

    // Back-to-back with I_REQ held high and inputs scrambled mid-cycle
    for (int i = 0; i < 6; i++)
      run_txn(1'(i), 1'(i >> 1), 16'(16'h3000 + i), 8'(i * 17), 8'(8'hE0 + i), 0, 1'b1);
    I_REQ = 1'b0;
    @(posedge I_CLK); #1;

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      run_txn(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(3, 0) == 0) ? int'($urandom_range(12, 1)) : 0,
              1'($urandom));
      gap = int'($urandom_range(2, 0));
      if (gap > 0) begin
        I_REQ = 1'b0;
        repeat (gap) begin
          @(posedge I_CLK); #1;
        end
      end
    end
    I_REQ = 1'b0;
    @(posedge I_CLK); #1;

`ifdef X1_BUSINIT_TIMEOUT_EN
    run_txn(1'b0, 1'b0, 16'hBEEF, 8'h00, 8'h12, 100000, 1'b0);
    run_txn(1'b1, 1'b1, 16'h0042, 8'h24, 8'h00, 100000, 1'b0);
    run_txn(1'b0, 1'b0, 16'h1234, 8'h00, 8'h34, 0, 1'b0);
`endif

    repeat (3) @(posedge I_CLK);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
